// File: rtl/mips_control.sv
// Multi-cycle control unit for the five-instruction Harvard MIPS core (ADDU, ADDIU, LW, SW, JR).
// Define MIPS_CTRL_DELAY_SLOT_EN to give JR one architectural delay slot.
module mips_control #(
    parameter logic RESET_ACTIVE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_readdata,
    input  logic        instr_waitrequest,
    output logic        instr_read,
    input  logic        data_waitrequest,
    output logic        data_read,
    output logic        data_write,
    input  logic        rs_is_zero,
    output logic        ir_write,
    output logic [5:0]  alu_op,
    output logic [5:0]  alu_func,
    output logic        alu_src_imm,
    output logic        reg_write,
    output logic        reg_dst_rd,
    output logic        mem_to_reg,
    output logic        pc_write,
    output logic        pc_src_reg,
    output logic        jt_write,
    output logic        active,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_JR    = 6'h08;

    state_t state;
    state_t state_next;

    logic is_addu;
    logic is_jr;
    logic is_addiu;
    logic is_lw;
    logic is_sw;
    logic fetch_accept;
    logic set_illegal;
    logic retire_halt;
    logic unused_instr_bits;

    // Only the opcode and function fields are needed here; the datapath owns the rest.
    assign unused_instr_bits = ^instr_readdata[25:6];

    always_comb begin
        is_addu  = (alu_op == OP_RTYPE) && (alu_func == FN_ADDU);
        is_jr    = (alu_op == OP_RTYPE) && (alu_func == FN_JR);
        is_addiu = (alu_op == OP_ADDIU);
        is_lw    = (alu_op == OP_LW);
        is_sw    = (alu_op == OP_SW);
    end

    assign fetch_accept = (state == S_FETCH) && !instr_waitrequest;

`ifdef MIPS_CTRL_DELAY_SLOT_EN
    logic jump_pending;
    logic halt_pending;

    // Halt only once the delay slot after a JR-to-zero has been fetched and retired.
    assign retire_halt = halt_pending && !jump_pending;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jump_pending <= 1'b0;
            halt_pending <= 1'b0;
        end else if (fetch_accept) begin
            jump_pending <= 1'b0;
        end else if ((state == S_EXEC) && is_jr) begin
            jump_pending <= 1'b1;
            halt_pending <= rs_is_zero;
        end
    end
`else
    assign retire_halt = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_op   <= '0;
            alu_func <= '0;
        end else if (fetch_accept) begin
            alu_op   <= instr_readdata[31:26];
            alu_func <= instr_readdata[5:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active  <= RESET_ACTIVE;
            illegal <= 1'b0;
        end else begin
            active  <= (state_next != S_HALT);
            illegal <= illegal | set_illegal;
        end
    end

    always_comb begin
        state_next  = state;
        set_illegal = 1'b0;
        case (state)
            S_FETCH: begin
                if (!instr_waitrequest) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                state_next = S_EXEC;
            end
            S_EXEC: begin
                if (is_addu || is_addiu) begin
                    state_next = S_WB;
                end else if (is_lw || is_sw) begin
                    state_next = S_MEM;
                end else if (is_jr) begin
`ifdef MIPS_CTRL_DELAY_SLOT_EN
                    state_next = S_FETCH;
`else
                    state_next = rs_is_zero ? S_HALT : S_FETCH;
`endif
                end else begin
                    state_next  = S_HALT;
                    set_illegal = 1'b1;
                end
            end
            S_MEM: begin
                if (!data_waitrequest) begin
                    if (is_lw) begin
                        state_next = S_WB;
                    end else begin
                        state_next = retire_halt ? S_HALT : S_FETCH;
                    end
                end
            end
            S_WB: begin
                state_next = retire_halt ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    always_comb begin
        instr_read  = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src_reg  = 1'b0;
        data_read   = 1'b0;
        data_write  = 1'b0;
        alu_src_imm = 1'b0;
        reg_write   = 1'b0;
        reg_dst_rd  = 1'b0;
        mem_to_reg  = 1'b0;
        jt_write    = 1'b0;
        case (state)
            S_FETCH: begin
                instr_read = 1'b1;
                ir_write   = !instr_waitrequest;
                pc_write   = !instr_waitrequest;
`ifdef MIPS_CTRL_DELAY_SLOT_EN
                pc_src_reg = jump_pending;
`endif
            end
            S_EXEC: begin
                alu_src_imm = is_addiu || is_lw || is_sw;
                if (is_jr) begin
`ifdef MIPS_CTRL_DELAY_SLOT_EN
                    jt_write   = 1'b1;
`else
                    pc_write   = 1'b1;
                    pc_src_reg = 1'b1;
`endif
                end
            end
            S_MEM: begin
                data_read  = is_lw;
                data_write = is_sw;
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst_rd = is_addu;
                mem_to_reg = is_lw;
            end
            default: begin
            end
        endcase
        // Async reset already forces FETCH; this also masks FETCH's instr_read while reset is held.
        if (reset) begin
            instr_read  = 1'b0;
            ir_write    = 1'b0;
            pc_write    = 1'b0;
            pc_src_reg  = 1'b0;
            data_read   = 1'b0;
            data_write  = 1'b0;
            alu_src_imm = 1'b0;
            reg_write   = 1'b0;
            reg_dst_rd  = 1'b0;
            mem_to_reg  = 1'b0;
            jt_write    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_control.sv
// Directed bench for mips_control: per-cycle expected strobes are queued, then popped and checked at negedge.
module tb_mips_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr_readdata = '0;
    logic        instr_waitrequest = 1'b0;
    logic        instr_read;
    logic        data_waitrequest = 1'b0;
    logic        data_read;
    logic        data_write;
    logic        rs_is_zero = 1'b0;
    logic        ir_write;
    logic [5:0]  alu_op;
    logic [5:0]  alu_func;
    logic        alu_src_imm;
    logic        reg_write;
    logic        reg_dst_rd;
    logic        mem_to_reg;
    logic        pc_write;
    logic        pc_src_reg;
    logic        jt_write;
    logic        active;
    logic        illegal;

    mips_control #(.RESET_ACTIVE(1'b1)) dut (
        .clk(clk),
        .reset(reset),
        .instr_readdata(instr_readdata),
        .instr_waitrequest(instr_waitrequest),
        .instr_read(instr_read),
        .data_waitrequest(data_waitrequest),
        .data_read(data_read),
        .data_write(data_write),
        .rs_is_zero(rs_is_zero),
        .ir_write(ir_write),
        .alu_op(alu_op),
        .alu_func(alu_func),
        .alu_src_imm(alu_src_imm),
        .reg_write(reg_write),
        .reg_dst_rd(reg_dst_rd),
        .mem_to_reg(mem_to_reg),
        .pc_write(pc_write),
        .pc_src_reg(pc_src_reg),
        .jt_write(jt_write),
        .active(active),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    localparam logic [12:0] B_IREAD = 13'h1000;
    localparam logic [12:0] B_IRW   = 13'h0800;
    localparam logic [12:0] B_PCW   = 13'h0400;
    localparam logic [12:0] B_PCSRC = 13'h0200;
    localparam logic [12:0] B_DRD   = 13'h0100;
    localparam logic [12:0] B_DWR   = 13'h0080;
    localparam logic [12:0] B_IMM   = 13'h0040;
    localparam logic [12:0] B_RW    = 13'h0020;
    localparam logic [12:0] B_RDST  = 13'h0010;
    localparam logic [12:0] B_M2R   = 13'h0008;
    localparam logic [12:0] B_JT    = 13'h0004;
    localparam logic [12:0] B_ACT   = 13'h0002;
    localparam logic [12:0] B_ILL   = 13'h0001;
    localparam logic [12:0] F_ACC   = B_IREAD | B_IRW | B_PCW | B_ACT;

    typedef struct {
        string       tag;
        logic [12:0] strobes;
        bit          chk_alu;
        logic [11:0] alu;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic cycle(input string tag, input logic [12:0] strobes,
                         input bit chk_alu = 1'b0, input logic [11:0] alu = '0);
        exp_t e;
        exp_t got;
        logic [12:0] obs;
        e.tag = tag;
        e.strobes = strobes;
        e.chk_alu = chk_alu;
        e.alu = alu;
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        obs = {instr_read, ir_write, pc_write, pc_src_reg, data_read, data_write,
               alu_src_imm, reg_write, reg_dst_rd, mem_to_reg, jt_write, active, illegal};
        checks++;
        assert (obs === got.strobes) else begin
            errors++;
            $error("FAIL %s strobes got=%b exp=%b", got.tag, obs, got.strobes);
        end
        if (got.chk_alu) begin
            checks++;
            assert ({alu_op, alu_func} === got.alu) else begin
                errors++;
                $error("FAIL %s alu got=%h exp=%h", got.tag, {alu_op, alu_func}, got.alu);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        cycle("reset", B_ACT, 1'b1, 12'h000);
        reset = 1'b0;

        // ADDU, zero waits
        instr_readdata = 32'h00851021;
        cycle("addu_fetch", F_ACC);
        cycle("addu_decode", B_ACT);
        cycle("addu_exec", B_ACT, 1'b1, {6'h00, 6'h21});
        cycle("addu_wb", B_RW | B_RDST | B_ACT);

        // LW with three data wait cycles
        instr_readdata = 32'h8C820004;
        cycle("lw_fetch", F_ACC);
        cycle("lw_decode", B_ACT);
        cycle("lw_exec", B_IMM | B_ACT, 1'b1, {6'h23, 6'h04});
        data_waitrequest = 1'b1;
        cycle("lw_mem_w1", B_DRD | B_ACT);
        cycle("lw_mem_w2", B_DRD | B_ACT);
        cycle("lw_mem_w3", B_DRD | B_ACT);
        data_waitrequest = 1'b0;
        cycle("lw_mem_go", B_DRD | B_ACT);
        cycle("lw_wb", B_RW | B_M2R | B_ACT);

        // SW with two instruction wait cycles
        instr_readdata = 32'hAC820008;
        instr_waitrequest = 1'b1;
        cycle("sw_fetch_w1", B_IREAD | B_ACT);
        cycle("sw_fetch_w2", B_IREAD | B_ACT);
        instr_waitrequest = 1'b0;
        cycle("sw_fetch_go", F_ACC);
        cycle("sw_decode", B_ACT);
        cycle("sw_exec", B_IMM | B_ACT, 1'b1, {6'h2B, 6'h08});
        cycle("sw_mem", B_DWR | B_ACT);

        // JR to address zero
        instr_readdata = 32'h00800008;
        rs_is_zero = 1'b1;
        cycle("jr_fetch", F_ACC);
        cycle("jr_decode", B_ACT);
`ifdef MIPS_CTRL_DELAY_SLOT_EN
        cycle("jr_exec", B_JT | B_ACT, 1'b1, {6'h00, 6'h08});
        rs_is_zero = 1'b0;
        instr_readdata = 32'h24420001;
        cycle("slot_fetch", F_ACC | B_PCSRC);
        cycle("slot_decode", B_ACT);
        cycle("slot_exec", B_IMM | B_ACT, 1'b1, {6'h09, 6'h01});
        cycle("slot_wb", B_RW | B_ACT);
        cycle("jr_halt1", '0);
        cycle("jr_halt2", '0, 1'b1, {6'h09, 6'h01});
`else
        cycle("jr_exec", B_PCW | B_PCSRC | B_ACT, 1'b1, {6'h00, 6'h08});
        rs_is_zero = 1'b0;
        cycle("jr_halt1", '0);
        cycle("jr_halt2", '0, 1'b1, {6'h00, 6'h08});
`endif

        reset = 1'b1;
        cycle("reset2", B_ACT, 1'b1, 12'h000);
        reset = 1'b0;

        // Illegal opcode (LUI)
        instr_readdata = 32'h3C010001;
        cycle("lui_fetch", F_ACC);
        cycle("lui_decode", B_ACT);
        cycle("lui_exec", B_ACT, 1'b1, {6'h0F, 6'h01});
        cycle("lui_halt1", B_ILL);
        cycle("lui_halt2", B_ILL);

        reset = 1'b1;
        cycle("reset3", B_ACT, 1'b1, 12'h000);
        reset = 1'b0;

        // Reset during an outstanding LW wait
        instr_readdata = 32'h8C820004;
        cycle("lw2_fetch", F_ACC);
        cycle("lw2_decode", B_ACT);
        cycle("lw2_exec", B_IMM | B_ACT, 1'b1, {6'h23, 6'h04});
        data_waitrequest = 1'b1;
        cycle("lw2_mem_w1", B_DRD | B_ACT);
        cycle("lw2_mem_w2", B_DRD | B_ACT);
        reset = 1'b1;
        cycle("lw2_reset", B_ACT, 1'b1, 12'h000);
        reset = 1'b0;
        data_waitrequest = 1'b0;
        instr_waitrequest = 1'b1;
        cycle("post_reset_fetch", B_IREAD | B_ACT);
        instr_waitrequest = 1'b0;
        cycle("post_reset_go", F_ACC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_control.md
# mips_control

Multi-cycle control unit for the five-instruction Harvard MIPS core (ADDU, ADDIU, LW, SW, JR). It sequences FETCH, DECODE, EXEC, MEM and WB over Avalon-style instruction and data memory ports with wait-request stalls. It drives the ALU's `ALUOp` and `func_code` inputs and the register-file, PC and memory strobes. It implements JR with an optional branch delay slot, halts on a jump to address 0, and halts on an illegal opcode.

## Interface
Parameters:
- `RESET_ACTIVE`, default 1: reset value of `active`.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `instr_readdata`  in  32  instruction word; valid when `instr_read`=1 and `instr_waitrequest`=0.
- `instr_waitrequest`  in  1  instruction memory stall.
- `instr_read`  out  1  instruction fetch request.
- `data_waitrequest`  in  1  data memory stall.
- `data_read`, `data_write`  out  1 each  data memory strobes for LW and SW.
- `rs_is_zero`  in  1  datapath flag: the register `rs` value is 0. Sampled in EXEC of JR.
- `ir_write`  out  1  datapath latches `instr_readdata` into the instruction register.
- `alu_op`  out  6  registered opcode (instr[31:26]) driven to the ALU's `ALUOp` input.
- `alu_func`  out  6  registered function code (instr[5:0]) driven to the ALU's `func_code` input.
- `alu_src_imm`  out  1  ALU op2 selects the sign-extended immediate (ADDIU, LW, SW).
- `reg_write`  out  1  register file write strobe.
- `reg_dst_rd`  out  1  write destination: 1 selects rd (ADDU), 0 selects rt.
- `mem_to_reg`  out  1  write-back data from memory (LW).
- `pc_write`  out  1  PC update strobe.
- `pc_src_reg`  out  1  PC source: 1 loads the jump target, 0 loads PC+4.
- `jt_write`  out  1  datapath latches `rs` into the jump-target register.
- `active`  out  1  1 while executing, 0 once halted.
- `illegal`  out  1  sticky flag: an illegal instruction caused the halt.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Reset enters FETCH.
- While `reset` is high:
  - all strobes are 0;
  - `alu_op` and `alu_func` are 0;
  - `active`=`RESET_ACTIVE` and `illegal`=0;
  - the jump-pending and halt-pending flags are cleared.
- FETCH:
  - `instr_read`=1; stay in FETCH while `instr_waitrequest`=1.
  - On the accept cycle: `ir_write`=1 and `pc_write`=1 (`pc_src_reg`=jump_pending); the opcode and function fields are registered; jump_pending is cleared; go to DECODE.
- DECODE: one cycle for the register-file read; no strobes.
- EXEC:
  - `alu_op` and `alu_func` are stable.
  - `alu_src_imm`=1 for opcodes 001001, 100011 and 101011.
  - ADDU (000000/100001) and ADDIU go to WB.
  - LW and SW go to MEM.
  - JR (000000/001000): `jt_write`=1, set jump_pending, set halt_pending if `rs_is_zero`, then go to FETCH.
  - Any other opcode or function: go to HALT and set `illegal`=1.
- MEM:
  - LW holds `data_read`=1 and SW holds `data_write`=1 until `data_waitrequest`=0.
  - Then LW goes to WB and SW goes to FETCH.
- WB: `reg_write`=1 for one cycle, with `reg_dst_rd`=1 for ADDU and `mem_to_reg`=1 for LW; then go to FETCH.
- Delay-slot halt: when an instruction retires with halt_pending=1 and jump_pending=0 (i.e. the delay slot has been fetched), go to HALT instead of FETCH.
- HALT:
  - Absorbing until reset.
  - All strobes are 0 and `active`=0.
  - `illegal` is held.
  - `alu_op` and `alu_func` hold their last values.
- JR in a delay slot: the new target overwrites the previous one, and halt_pending is re-evaluated from `rs_is_zero`.
- Reset asserted mid-operation, including during an outstanding memory wait, returns to FETCH immediately and drops all strobes.

## Timing
- Latency with zero wait states:
  - ADDU and ADDIU: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LW: 5 cycles.
  - SW: 4 cycles.
  - JR: 3 cycles.
- Each wait-request cycle adds one cycle.
- All outputs are Moore functions of the state and registered fields, except the FETCH and MEM exit strobes. `ir_write`, `pc_write` and the MEM transition are qualified combinationally by wait-request low.
- `instr_read` first asserts in the first cycle after `reset` deasserts.

## Configuration
- `MIPS_CTRL_DELAY_SLOT_EN` defined:
  - JR has one architectural delay slot, using jump_pending and halt_pending as described in Operation.
- `MIPS_CTRL_DELAY_SLOT_EN` undefined:
  - JR in EXEC asserts `pc_write`=1 and `pc_src_reg`=1 directly; `jt_write` stays 0.
  - If `rs_is_zero`, JR goes straight to HALT.
  - FETCH always uses `pc_src_reg`=0.

## Test plan
- ADDU (0x00851021) with zero waits:
  - `ir_write` pulses in cycle 1.
  - `alu_op`=000000 and `alu_func`=100001 in EXEC.
  - `reg_write`=1 and `reg_dst_rd`=1 in cycle 4.
  - `instr_read`=1 again in cycle 5.
- LW (0x8C820004) with `data_waitrequest` high for 3 cycles:
  - `data_read` is held for 4 cycles and `alu_src_imm`=1.
  - `reg_write`=1 and `mem_to_reg`=1 one cycle after the wait ends.
- SW with `instr_waitrequest` high for 2 cycles:
  - `ir_write` and `pc_write` fire only on the third FETCH cycle.
  - `data_write` for 1 cycle; `reg_write` never asserts.
- JR with `rs_is_zero`=1, followed by an ADDIU (with `MIPS_CTRL_DELAY_SLOT_EN`):
  - `jt_write` in EXEC.
  - The ADDIU fetch asserts `pc_src_reg`=1.
  - The ADDIU completes its WB; then `active`=0 and `instr_read` stays 0.
- Same JR without `MIPS_CTRL_DELAY_SLOT_EN`: `pc_write` and `pc_src_reg` in EXEC, and `active`=0 the next cycle with no further fetch.
- Illegal opcode 0x3C010001 (LUI):
  - HALT with `illegal`=1 and `active`=0.
  - Asserting `reset` mid-MEM of a later run clears `illegal` and drops `data_read` immediately.
